multi_watchdog: RTL and testbench
=================================

MULTI_WATCHDOG -- requirements
Module: multi_watchdog

Interface
REQ-001 NUM_CHANNELS, 4, number of independent watchdog channels (legal 1..16).
REQ-002 COUNTER_WIDTH, 32, width of each down-counter and timeout value.
REQ-003 PRESCALE_WIDTH, 8, width of the shared prescaler divide value.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 prescale  input  PRESCALE_WIDTH  tick period is prescale+1 clk cycles.
REQ-007 cfg_we  input  1  write cfg_timeout/cfg_auto_reload into channel cfg_channel.
REQ-008 cfg_channel  input  max(1,$clog2(NUM_CHANNELS))  channel selected for config.
REQ-009 cfg_timeout  input  COUNTER_WIDTH  reload value.
REQ-010 cfg_auto_reload  input  1  1 = auto-reload mode, 0 = one-shot mode.
REQ-011 enable  input  NUM_CHANNELS  per-channel run level.
REQ-012 kick  input  NUM_CHANNELS  per-channel service pulse.
REQ-013 clear  input  NUM_CHANNELS  per-channel sticky-flag clear.
REQ-014 mon_channel  input  same width as cfg_channel  selects channel driven on counter.
REQ-015 timeout  output  NUM_CHANNELS  sticky expiry flags, registered.
REQ-016 timeout_pulse  output  NUM_CHANNELS  one-cycle pulse per expiry, registered.
REQ-017 irq  output  1  OR of timeout.
REQ-018 counter  output  COUNTER_WIDTH  current count of mon_channel (combinational mux of registers).

Function
REQ-019 Prescaler: shared counter; when count >= prescale, tick is high for one cycle and count wraps to 0, else count increments; prescale=0 gives a tick every cycle.
REQ-020 Per-channel FSM states: IDLE, COUNTING, EXPIRED.
REQ-021 IDLE with enable=1: load counter from the channel timeout register and enter COUNTING on the same edge.
REQ-022 COUNTING on tick: counter!=0 -> decrement; counter==0 -> expiry event.
REQ-023 Expiry: timeout flag set and timeout_pulse high for one cycle after the edge; one-shot -> EXPIRED with counter held at 0; auto-reload -> reload counter, remain COUNTING.
REQ-024 Kick in COUNTING reloads the counter with no decrement that cycle; kick has priority over a coincident tick/expiry (no expiry is raised).
REQ-025 Kick in IDLE or EXPIRED is ignored.
REQ-026 Clear in EXPIRED -> IDLE and flag cleared; clear in other states only clears the flag.
REQ-027 Clear coincident with an expiry: expiry wins, flag remains set.
REQ-028 enable=0 in any state -> IDLE next edge, counter value held, timeout flag unchanged.
REQ-029 Config write updates the timeout/mode registers only; a running count is unaffected until the next load (enable, kick or auto-reload).
REQ-030 Config write with cfg_channel >= NUM_CHANNELS is ignored; mon_channel out of range drives counter to 0.
REQ-031 Timeout value T gives expiry on the (T+1)th tick after load; T=0 expires on the first tick.
REQ-032 Channels are fully independent; simultaneous expiries on several channels all flag in the same cycle.

Reset
REQ-033 While rst_n=0 at an edge: all FSMs IDLE, counters 0, prescaler 0, timeout registers all-ones, mode one-shot, timeout/timeout_pulse/irq 0.
REQ-034 Reset mid-count or mid-expiry discards all state; no pulse is emitted for the aborted count.

Structure
REQ-035 Package multi_watchdog_pkg holds the FSM state enum typedef and the default parameter constants.
REQ-036 One sub-module, watchdog_channel (FSM, counter, timeout/mode registers, flag), generated NUM_CHANNELS times; the prescaler, config decode, irq OR and monitor mux stay in multi_watchdog.

Verification
REQ-037 prescale=0, ch0 timeout=3 one-shot, enable[0] high -> timeout_pulse[0] high after the 5th edge with enable high, timeout[0]/irq stay 1, counter holds 0.
REQ-038 Same setup, kick[0] every 3 cycles for 50 cycles -> no expiry; drop the kicks -> expiry 4 ticks after the last kick.
REQ-039 prescale=3, ch1 timeout=2 auto-reload -> timeout_pulse[1] every 12 cycles, FSM never enters EXPIRED.
REQ-040 Kick and the expiring tick in the same cycle -> no pulse, counter reloaded; clear and expiry in the same cycle -> flag set.
REQ-041 All 4 channels timeout=1, enabled together -> 4 pulses in one cycle; clear[2] -> only timeout[2] drops, irq stays 1.
REQ-042 rst_n low for one edge mid-count on ch0 -> all outputs 0, timeout register reads all-ones via reload on next enable.

Source files
------------

// File: rtl/multi_watchdog_pkg.sv
// Shared types and default sizing for the multi-channel watchdog.
package multi_watchdog_pkg;

    localparam int DEF_NUM_CHANNELS   = 4;
    localparam int DEF_COUNTER_WIDTH  = 32;
    localparam int DEF_PRESCALE_WIDTH = 8;

    typedef enum logic [1:0] {
        WD_IDLE     = 2'd0,
        WD_COUNTING = 2'd1,
        WD_EXPIRED  = 2'd2
    } wd_state_e;

endpackage

// File: rtl/watchdog_channel.sv
// One watchdog channel: reload registers, down-counter, FSM and sticky expiry flag.
module watchdog_channel
    import multi_watchdog_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tick,
    input  logic                     cfg_we,
    input  logic [COUNTER_WIDTH-1:0] cfg_timeout,
    input  logic                     cfg_auto_reload,
    input  logic                     enable,
    input  logic                     kick,
    input  logic                     clear,
    output logic                     timeout,
    output logic                     timeout_pulse,
    output logic [COUNTER_WIDTH-1:0] count
);

    wd_state_e                state_q, state_d;
    logic [COUNTER_WIDTH-1:0] cnt_q;
    logic [COUNTER_WIDTH-1:0] tmo_q;
    logic                     auto_q;
    logic                     flag_q;
    logic                     pulse_q;
    logic                     expire;
    logic                     load;
    logic                     dec;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= WD_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WD_IDLE:     if (enable) state_d = WD_COUNTING;
            WD_COUNTING: begin
                if (!enable)                 state_d = WD_IDLE;
                else if (expire && !auto_q)  state_d = WD_EXPIRED;
            end
            WD_EXPIRED:  if (!enable || clear) state_d = WD_IDLE;
            default:     state_d = WD_IDLE;
        endcase
    end

    // Kick outranks the tick, so a kick on the expiring tick suppresses the expiry.
    always_comb begin
        expire = 1'b0;
        load   = 1'b0;
        dec    = 1'b0;
        case (state_q)
            WD_IDLE:     load = enable;
            WD_COUNTING: begin
                if (enable) begin
                    if (kick) begin
                        load = 1'b1;
                    end else if (tick) begin
                        if (cnt_q == '0) begin
                            expire = 1'b1;
                            load   = auto_q;
                        end else begin
                            dec = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            tmo_q   <= '1;
            auto_q  <= 1'b0;
            flag_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            if (cfg_we) begin
                tmo_q  <= cfg_timeout;
                auto_q <= cfg_auto_reload;
            end
            if (load)     cnt_q <= tmo_q;
            else if (dec) cnt_q <= cnt_q - COUNTER_WIDTH'(1);
            pulse_q <= expire;
            if (expire)     flag_q <= 1'b1;
            else if (clear) flag_q <= 1'b0;
        end
    end

    assign timeout       = flag_q;
    assign timeout_pulse = pulse_q;
    assign count         = cnt_q;

endmodule

// File: rtl/multi_watchdog.sv
// Bank of independent watchdog channels sharing one prescaler, config port and monitor mux.
module multi_watchdog
    import multi_watchdog_pkg::*;
#(
    parameter int  NUM_CHANNELS   = DEF_NUM_CHANNELS,
    parameter int  COUNTER_WIDTH  = DEF_COUNTER_WIDTH,
    parameter int  PRESCALE_WIDTH = DEF_PRESCALE_WIDTH,
    localparam int CH_W           = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      cfg_we,
    input  logic [CH_W-1:0]           cfg_channel,
    input  logic [COUNTER_WIDTH-1:0]  cfg_timeout,
    input  logic                      cfg_auto_reload,
    input  logic [NUM_CHANNELS-1:0]   enable,
    input  logic [NUM_CHANNELS-1:0]   kick,
    input  logic [NUM_CHANNELS-1:0]   clear,
    input  logic [CH_W-1:0]           mon_channel,
    output logic [NUM_CHANNELS-1:0]   timeout,
    output logic [NUM_CHANNELS-1:0]   timeout_pulse,
    output logic                      irq,
    output logic [COUNTER_WIDTH-1:0]  counter
);

    logic [PRESCALE_WIDTH-1:0]                   ps_q;
    logic                                        tick;
    logic [NUM_CHANNELS-1:0][COUNTER_WIDTH-1:0]  cnt_arr;

    // ">=" rather than "==" so lowering prescale mid-period cannot strand the count.
    assign tick = (ps_q >= prescale);

    always_ff @(posedge clk) begin
        if (!rst_n)    ps_q <= '0;
        else if (tick) ps_q <= '0;
        else           ps_q <= ps_q + PRESCALE_WIDTH'(1);
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        logic ch_we;
        assign ch_we = cfg_we && (cfg_channel == CH_W'(i));

        watchdog_channel #(
            .COUNTER_WIDTH (COUNTER_WIDTH)
        ) u_ch (
            .clk             (clk),
            .rst_n           (rst_n),
            .tick            (tick),
            .cfg_we          (ch_we),
            .cfg_timeout     (cfg_timeout),
            .cfg_auto_reload (cfg_auto_reload),
            .enable          (enable[i]),
            .kick            (kick[i]),
            .clear           (clear[i]),
            .timeout         (timeout[i]),
            .timeout_pulse   (timeout_pulse[i]),
            .count           (cnt_arr[i])
        );
    end

    // Unmatched (out-of-range) selects fall through to zero.
    always_comb begin
        counter = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (mon_channel == CH_W'(i)) counter = cnt_arr[i];
        end
    end

    assign irq = |timeout;

endmodule

// File: tb/tb_multi_watchdog.sv
// Scoreboard bench for multi_watchdog: expected pulses queued with their cycle, plus inline state checks.
module tb_multi_watchdog;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  prescale;
    logic        cfg_we;
    logic [1:0]  cfg_channel;
    logic [31:0] cfg_timeout;
    logic        cfg_auto_reload;
    logic [3:0]  enable, kick, clear;
    logic [1:0]  mon_channel;
    logic [3:0]  timeout, timeout_pulse;
    logic        irq;
    logic [31:0] counter;
    logic [2:0]  t3_timeout, t3_pulse;
    logic        t3_irq;
    logic [7:0]  t3_counter;

    typedef struct {
        int         cyc;
        logic [3:0] vec;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   passed = 0;
    int   total  = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multi_watchdog dut (
        .clk(clk), .rst_n(rst_n), .prescale(prescale), .cfg_we(cfg_we),
        .cfg_channel(cfg_channel), .cfg_timeout(cfg_timeout),
        .cfg_auto_reload(cfg_auto_reload), .enable(enable), .kick(kick),
        .clear(clear), .mon_channel(mon_channel), .timeout(timeout),
        .timeout_pulse(timeout_pulse), .irq(irq), .counter(counter)
    );

    // Three-channel instance exercises the out-of-range config and monitor selects.
    multi_watchdog #(.NUM_CHANNELS(3), .COUNTER_WIDTH(8), .PRESCALE_WIDTH(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .prescale(prescale), .cfg_we(cfg_we),
        .cfg_channel(cfg_channel), .cfg_timeout(cfg_timeout[7:0]),
        .cfg_auto_reload(cfg_auto_reload), .enable(enable[2:0]), .kick(kick[2:0]),
        .clear(clear[2:0]), .mon_channel(mon_channel), .timeout(t3_timeout),
        .timeout_pulse(t3_pulse), .irq(t3_irq), .counter(t3_counter)
    );

    // Every pulse on the main instance must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (timeout_pulse !== 4'b0) begin
                total++;
                if (sb.size() == 0) begin
                    $display("FAIL pulse_unexpected cyc=%0d got=%b expected none", cyc, timeout_pulse);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.cyc == cyc && mon_e.vec === timeout_pulse) passed++;
                    else $display("FAIL pulse cyc=%0d got=%b expected cyc=%0d vec=%b",
                                  cyc, timeout_pulse, mon_e.cyc, mon_e.vec);
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                total++;
                mon_e = sb.pop_front();
                $display("FAIL pulse_missed cyc=%0d got=%b expected cyc=%0d vec=%b",
                         cyc, timeout_pulse, mon_e.cyc, mon_e.vec);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [7:0] ps);
        rst_n = 1'b0; enable = '0; kick = '0; clear = '0; cfg_we = 1'b0;
        cfg_channel = '0; cfg_timeout = '0; cfg_auto_reload = 1'b0;
        mon_channel = '0; prescale = ps;
        step(2);
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic cfg_write(input int ch, input logic [31:0] t, input logic ar);
        cfg_we = 1'b1; cfg_channel = ch[1:0]; cfg_timeout = t; cfg_auto_reload = ar;
        step(1);
        cfg_we = 1'b0;
    endtask

    task automatic test_reset;
        do_reset(8'd0);
        total++; if (timeout !== 4'b0) $display("FAIL reset_timeout got=%b exp=0", timeout); else passed++;
        total++; if (timeout_pulse !== 4'b0) $display("FAIL reset_pulse got=%b exp=0", timeout_pulse); else passed++;
        total++; if (irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", irq); else passed++;
        total++; if (counter !== 32'd0) $display("FAIL reset_counter got=%h exp=0", counter); else passed++;
    endtask

    task automatic test_oneshot;
        do_reset(8'd0);
        cfg_write(0, 32'd3, 1'b0);
        enable = 4'b0001;
        sb.push_back('{cyc + 5, 4'b0001});
        step(1);
        total++; if (counter !== 32'd3) $display("FAIL os_load got=%0d exp=3", counter); else passed++;
        step(4);
        total++; if (timeout[0] !== 1'b1 || irq !== 1'b1)
            $display("FAIL os_flag got=%b/%b exp=1/1", timeout[0], irq); else passed++;
        total++; if (counter !== 32'd0) $display("FAIL os_hold got=%0d exp=0", counter); else passed++;
        kick = 4'b0001; step(1); kick = '0; step(2);
        total++; if (counter !== 32'd0 || timeout[0] !== 1'b1)
            $display("FAIL os_kick_ignored got=%0d/%b exp=0/1", counter, timeout[0]); else passed++;
        clear = 4'b0001; step(1); clear = '0;
        total++; if (timeout[0] !== 1'b0 || irq !== 1'b0)
            $display("FAIL os_clear got=%b/%b exp=0/0", timeout[0], irq); else passed++;
        step(1);
        total++; if (counter !== 32'd3) $display("FAIL os_reload got=%0d exp=3", counter); else passed++;
        enable = '0;
        step(2);
        total++; if (counter !== 32'd3 || timeout[0] !== 1'b0)
            $display("FAIL os_disable got=%0d/%b exp=3/0", counter, timeout[0]); else passed++;
    endtask

    task automatic test_kick;
        do_reset(8'd0);
        cfg_write(0, 32'd3, 1'b0);
        enable = 4'b0001;
        for (int i = 0; i < 50; i++) begin
            kick = (i % 3 == 0) ? 4'b0001 : 4'b0000;
            if (i == 48) sb.push_back('{cyc + 5, 4'b0001});
            step(1);
        end
        kick = '0;
        total++; if (timeout[0] !== 1'b0 || counter !== 32'd2)
            $display("FAIL kick_hold got=%b/%0d exp=0/2", timeout[0], counter); else passed++;
        step(3);
        total++; if (timeout[0] !== 1'b1) $display("FAIL kick_expire got=%b exp=1", timeout[0]); else passed++;
    endtask

    task automatic test_autoreload;
        int r;
        do_reset(8'd3);
        r = cyc;
        cfg_write(1, 32'd2, 1'b1);
        enable = 4'b0010;
        mon_channel = 2'd1;
        for (int k = 1; k <= 4; k++) sb.push_back('{r + 12 * k, 4'b0010});
        step(49);
        total++; if (timeout[1] !== 1'b1 || counter !== 32'd2)
            $display("FAIL ar_state got=%b/%0d exp=1/2", timeout[1], counter); else passed++;
        enable = '0;
        step(1);
    endtask

    task automatic test_coincident;
        do_reset(8'd0);
        cfg_write(0, 32'd1, 1'b0);
        enable = 4'b0001;
        step(2);
        total++; if (counter !== 32'd0) $display("FAIL co_pre got=%0d exp=0", counter); else passed++;
        kick = 4'b0001; step(1); kick = '0;
        total++; if (counter !== 32'd1 || timeout[0] !== 1'b0)
            $display("FAIL co_kick got=%0d/%b exp=1/0", counter, timeout[0]); else passed++;
        step(1);
        clear = 4'b0001;
        sb.push_back('{cyc + 1, 4'b0001});
        step(1);
        clear = '0;
        total++; if (timeout[0] !== 1'b1) $display("FAIL co_clear got=%b exp=1", timeout[0]); else passed++;
        enable = '0;
    endtask

    task automatic test_multi;
        do_reset(8'd0);
        for (int ch = 0; ch < 4; ch++) cfg_write(ch, 32'd1, 1'b0);
        enable = 4'hF;
        sb.push_back('{cyc + 3, 4'hF});
        step(3);
        total++; if (timeout !== 4'hF) $display("FAIL mc_all got=%b exp=1111", timeout); else passed++;
        clear = 4'b0100; step(1); clear = '0;
        total++; if (timeout !== 4'b1011 || irq !== 1'b1)
            $display("FAIL mc_clear got=%b/%b exp=1011/1", timeout, irq); else passed++;
        enable = '0;
    endtask

    task automatic test_reset_mid;
        do_reset(8'd0);
        cfg_write(0, 32'd5, 1'b0);
        enable = 4'b0001;
        step(3);
        total++; if (counter !== 32'd3) $display("FAIL rm_count got=%0d exp=3", counter); else passed++;
        rst_n = 1'b0; step(1); rst_n = 1'b1;
        total++; if (timeout !== 4'b0 || timeout_pulse !== 4'b0 || irq !== 1'b0 || counter !== 32'd0)
            $display("FAIL rm_outputs got=%b/%b/%b/%h exp=0/0/0/0", timeout, timeout_pulse, irq, counter);
        else passed++;
        step(1);
        total++; if (counter !== 32'hFFFF_FFFF) $display("FAIL rm_reload got=%h exp=ffffffff", counter); else passed++;
        enable = '0;
    endtask

    task automatic test_out_of_range;
        do_reset(8'd0);
        cfg_write(3, 32'd5, 1'b0);
        enable = 4'b1001;
        step(1);
        mon_channel = 2'd3; #1;
        total++; if (counter !== 32'd5) $display("FAIL oor_main got=%0d exp=5", counter); else passed++;
        total++; if (t3_counter !== 8'd0) $display("FAIL oor_mon got=%0d exp=0", t3_counter); else passed++;
        mon_channel = 2'd0; #1;
        total++; if (t3_counter !== 8'hFF) $display("FAIL oor_cfg got=%h exp=ff", t3_counter); else passed++;
        enable = '0;
        step(1);
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_kick();
        test_autoreload();
        test_coincident();
        test_multi();
        test_reset_mid();
        test_out_of_range();
        step(5);
        total++;
        if (sb.size() != 0) $display("FAIL sb_drain got=%0d pending exp=0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
